// File: rtl/demod_pkg.sv
// demod_pkg: shared state encoding, error codes and symbol width for the frame controller
package demod_pkg;
  localparam int SYM_W = 2;
  typedef enum logic [2:0] {IDLE, HUNT, LEN, PAYLOAD, CHECK, RESYNC} state_t;
  localparam logic [1:0] ERR_CSUM = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;
endpackage

// File: rtl/demod_frame_ctrl_if.sv
// demod_frame_ctrl_if: symbol input, demod sequencing, payload byte stream and frame status
interface demod_frame_ctrl_if;
  import demod_pkg::*;
  logic [SYM_W-1:0] sym_in;
  logic sym_valid;
  logic demod_locked;
  logic demod_resync;
  logic [7:0] byte_out;
  logic byte_valid;
  logic byte_ready;
  logic frame_start;
  logic frame_end;
  logic frame_err;
  logic [1:0] err_code;
  logic busy;
  modport master (
    output sym_in, sym_valid, demod_locked, byte_ready,
    input demod_resync, byte_out, byte_valid, frame_start, frame_end, frame_err, err_code, busy
  );
  modport slave (
    input sym_in, sym_valid, demod_locked, byte_ready,
    output demod_resync, byte_out, byte_valid, frame_start, frame_end, frame_err, err_code, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_wr, w_rd;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);
  // head is masked so the output reads zero whenever nothing is queued
  assign o_data = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_wr);
      r_rd <= r_rd + AW'(w_rd);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk) if (w_wr) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/demod_frame_ctrl.sv
// demod_frame_ctrl: sync hunt, length/checksum frame parsing, payload FIFO and demod resync sequencing
module demod_frame_ctrl
  import demod_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = 16'h1ACF,
  parameter logic [7:0] MAX_LEN = 8'd64,
  parameter logic [15:0] TIMEOUT = 16'd4096,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk_fast,
  input logic rst,
  demod_frame_ctrl_if.slave io
);
  state_t r_state, w_next;
  logic [15:0] r_sh, r_tmo, w_sh;
  logic [3*SYM_W-1:0] r_acc;
  logic [1:0] r_cnt, r_code, w_code;
  logic [7:0] r_rem, r_sum, w_byte, w_dout;
  logic r_start, r_end, r_err;
  logic w_bdone, w_live, w_sync, w_chk, w_abort, w_push, w_pop, w_full, w_empty;
  assign w_sh = {r_sh[15-SYM_W:0], io.sym_in};
  assign w_byte = {r_acc, io.sym_in};
  assign w_bdone = io.sym_valid && r_cnt == 2'd3;
  assign w_live = r_state inside {LEN, PAYLOAD, CHECK};
  assign w_pop = !w_empty && io.byte_ready;
  assign w_sync = r_state == HUNT && w_next == LEN;
  assign w_chk = r_state == CHECK && w_bdone && !w_abort;
  always_comb begin
    w_next = r_state;
    w_abort = 1'b0;
    w_code = ERR_TMO;
    w_push = 1'b0;
    case (r_state)
      IDLE: w_next = io.demod_locked ? HUNT : IDLE;
      HUNT: w_next = !io.demod_locked ? IDLE : (io.sym_valid && w_sh == SYNC_WORD) ? LEN : HUNT;
      LEN: if (w_bdone) begin
        w_abort = w_byte == '0 || w_byte > MAX_LEN;
        w_code = ERR_LEN;
        w_next = PAYLOAD;
      end
      PAYLOAD: if (w_bdone) begin
        w_abort = w_full && !w_pop;
        w_code = ERR_OVF;
        w_push = !w_abort;
        w_next = r_rem == 8'd1 ? CHECK : PAYLOAD;
      end
      CHECK: w_next = w_bdone ? RESYNC : CHECK;
      RESYNC: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // lock loss and symbol starvation override any byte event in the same cycle
    if (w_live && (!io.demod_locked || (!io.sym_valid && r_tmo == TIMEOUT - 16'd1))) begin
      w_abort = 1'b1;
      w_code = ERR_TMO;
      w_push = 1'b0;
    end
    if (w_abort) w_next = RESYNC;
  end
  always_ff @(posedge clk_fast) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_sh <= '0;
      r_tmo <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_rem <= '0;
      r_sum <= '0;
      r_start <= 1'b0;
      r_end <= 1'b0;
      r_err <= 1'b0;
      r_code <= '0;
    end else begin
      r_sh <= (r_state == HUNT && w_next == HUNT) ? (io.sym_valid ? w_sh : r_sh) : '0;
      r_tmo <= (w_live && !io.sym_valid) ? r_tmo + 16'd1 : '0;
      r_acc <= (w_live && io.sym_valid) ? {r_acc[2*SYM_W-1:0], io.sym_in} : r_acc;
      r_cnt <= w_sync ? '0 : (w_live && io.sym_valid) ? r_cnt + 2'd1 : r_cnt;
      r_rem <= (r_state == LEN && w_bdone) ? w_byte : w_push ? r_rem - 8'd1 : r_rem;
      r_sum <= w_sync ? '0 : (r_state == LEN && w_bdone) ? w_byte : w_push ? r_sum + w_byte : r_sum;
      r_start <= w_sync;
      r_end <= w_abort || w_chk;
      r_err <= w_abort || (w_chk && w_byte != r_sum);
      r_code <= w_sync ? ERR_CSUM : w_abort ? w_code : r_code;
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_fast),
    .rst(rst),
    .i_push(w_push),
    .i_data(w_byte),
    .i_pop(w_pop),
    .o_data(w_dout),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign io.byte_out = w_dout;
  assign io.byte_valid = !w_empty;
  assign io.demod_resync = r_state == RESYNC;
  assign io.busy = !(r_state inside {IDLE, HUNT});
  assign io.frame_start = r_start;
  assign io.frame_end = r_end;
  assign io.frame_err = r_err;
  assign io.err_code = r_code;
endmodule

// File: tb/tb_demod_frame_ctrl.sv
// tb_demod_frame_ctrl: directed frame scenarios against hand-computed expectations
module tb_demod_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tog = 1'b0;
  int checks = 0, errors = 0;
  int cyc = 0, n_start = 0, n_end = 0, n_res = 0, n_got = 0, t_sv = 0, t_end = 0;
  int s_start, s_end, s_res, s_got;
  logic last_err = 1'b0;
  logic [1:0] last_code = 2'd0;
  logic [7:0] got [256];
  demod_frame_ctrl_if io();
  demod_frame_ctrl dut (.clk_fast(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    cyc++;
    if (io.sym_valid) t_sv = cyc;
    if (io.frame_start) n_start++;
    if (io.frame_end) begin
      n_end++;
      t_end = cyc;
      last_err = io.frame_err;
      last_code = io.err_code;
    end
    if (io.demod_resync) n_res++;
    if (io.byte_valid && io.byte_ready && n_got < 256) begin
      got[n_got] = io.byte_out;
      n_got++;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (tog) io.byte_ready = !io.byte_ready;
  endtask
  task automatic send_sym(input logic [1:0] s);
    io.sym_in = s;
    io.sym_valid = 1'b1;
    step();
    io.sym_valid = 1'b0;
    step();
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) send_sym(b[2*i +: 2]);
  endtask
  task automatic send_sync();
    logic [15:0] w;
    w = 16'h1ACF;
    for (int i = 7; i >= 0; i--) send_sym(w[2*i +: 2]);
  endtask
  task automatic snap();
    s_start = n_start;
    s_end = n_end;
    s_res = n_res;
    s_got = n_got;
  endtask
  task automatic finish_frame(input string tag);
    for (int i = 0; i < 40 && n_res == s_res; i++) step();
    check({tag, "_resync"}, n_res - s_res, 1);
    io.demod_locked = 1'b0;
    step();
    step();
    check({tag, "_idle"}, io.busy, 0);
    io.demod_locked = 1'b1;
    step();
    step();
  endtask
  initial begin
    io.sym_in = 2'd0;
    io.sym_valid = 1'b0;
    io.demod_locked = 1'b0;
    io.byte_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_valid", io.byte_valid, 0);
    check("rst_busy", io.busy, 0);
    check("rst_code", io.err_code, 0);
    check("rst_end", io.frame_end, 0);
    check("rst_resync", io.demod_resync, 0);
    check("rst_byte", io.byte_out, 0);
    step();
    rst = 1'b0;
    io.demod_locked = 1'b1;
    step();
    step();
    check("hunt_busy", io.busy, 0);
    // good frame
    snap();
    send_sync();
    check("len_busy", io.busy, 1);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h69);
    step();
    check("good_start", n_start - s_start, 1);
    check("good_end", n_end - s_end, 1);
    check("good_err", last_err, 0);
    check("good_nbytes", n_got - s_got, 3);
    check("good_b0", got[s_got], 8'h11);
    check("good_b1", got[s_got+1], 8'h22);
    check("good_b2", got[s_got+2], 8'h33);
    finish_frame("good");
    // length zero
    snap();
    send_sync();
    send_byte(8'h00);
    step();
    check("len0_end", n_end - s_end, 1);
    check("len0_err", last_err, 1);
    check("len0_code", last_code, 1);
    check("len0_nopush", n_got - s_got, 0);
    finish_frame("len0");
    // length above MAX_LEN
    snap();
    send_sync();
    send_byte(8'h41);
    step();
    check("len41_end", n_end - s_end, 1);
    check("len41_err", last_err, 1);
    check("len41_code", last_code, 1);
    check("len41_valid", io.byte_valid, 0);
    finish_frame("len41");
    // bad checksum
    snap();
    send_sync();
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h68);
    step();
    check("csum_end", n_end - s_end, 1);
    check("csum_err", last_err, 1);
    check("csum_code", last_code, 0);
    check("csum_nbytes", n_got - s_got, 3);
    finish_frame("csum");
    // overflow under backpressure, with first-byte latency
    io.byte_ready = 1'b0;
    snap();
    send_sync();
    send_byte(8'h06);
    send_sym(2'd0);
    send_sym(2'd0);
    send_sym(2'd0);
    io.sym_in = 2'd1;
    io.sym_valid = 1'b1;
    @(negedge clk);
    check("lat_t", io.byte_valid, 0);
    step();
    io.sym_valid = 1'b0;
    @(negedge clk);
    check("lat_t1", io.byte_valid, 1);
    check("lat_data", io.byte_out, 8'h01);
    step();
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    step();
    check("ovf_end", n_end - s_end, 1);
    check("ovf_err", last_err, 1);
    check("ovf_code", last_code, 2);
    check("ovf_head", io.byte_out, 8'h01);
    io.byte_ready = 1'b1;
    repeat (6) step();
    check("ovf_nbytes", n_got - s_got, 4);
    check("ovf_b0", got[s_got], 8'h01);
    check("ovf_b3", got[s_got+3], 8'h04);
    check("ovf_empty", io.byte_valid, 0);
    finish_frame("ovf");
    // push and pop together while full
    io.byte_ready = 1'b0;
    snap();
    send_sync();
    send_byte(8'h05);
    send_byte(8'hb1);
    send_byte(8'hb2);
    send_byte(8'hb3);
    send_byte(8'hb4);
    send_sym(2'd2);
    send_sym(2'd3);
    send_sym(2'd1);
    io.byte_ready = 1'b1;
    send_sym(2'd1);
    send_byte(8'h84);
    step();
    check("full_end", n_end - s_end, 1);
    check("full_err", last_err, 0);
    repeat (6) step();
    check("full_nbytes", n_got - s_got, 5);
    check("full_b0", got[s_got], 8'hb1);
    check("full_b4", got[s_got+4], 8'hb5);
    finish_frame("full");
    // ready toggling every cycle
    tog = 1'b1;
    snap();
    send_sync();
    send_byte(8'h06);
    send_byte(8'ha1);
    send_byte(8'ha2);
    send_byte(8'ha3);
    send_byte(8'ha4);
    send_byte(8'ha5);
    send_byte(8'ha6);
    send_byte(8'hdb);
    step();
    tog = 1'b0;
    io.byte_ready = 1'b1;
    repeat (6) step();
    check("tog_end", n_end - s_end, 1);
    check("tog_err", last_err, 0);
    check("tog_nbytes", n_got - s_got, 6);
    check("tog_b0", got[s_got], 8'ha1);
    check("tog_b5", got[s_got+5], 8'ha6);
    finish_frame("tog");
    // timeout after the length byte
    snap();
    send_sync();
    send_byte(8'h03);
    for (int i = 0; i < 5000 && n_end == s_end; i++) step();
    check("tmo_end", n_end - s_end, 1);
    check("tmo_err", last_err, 1);
    check("tmo_code", last_code, 3);
    check("tmo_cycles", t_end - t_sv, 4097);
    finish_frame("tmo");
    // lock loss mid-payload
    snap();
    send_sync();
    send_byte(8'h03);
    send_byte(8'h11);
    io.demod_locked = 1'b0;
    @(negedge clk);
    check("lock_end_t", io.frame_end, 0);
    step();
    check("lock_end_t1", io.frame_end, 1);
    check("lock_err", io.frame_err, 1);
    check("lock_code", io.err_code, 3);
    finish_frame("lock");
    // reset mid-payload with two bytes queued
    io.byte_ready = 1'b0;
    snap();
    send_sync();
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    check("pre_rst_valid", io.byte_valid, 1);
    check("pre_rst_busy", io.busy, 1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", io.byte_valid, 0);
    check("mid_rst_byte", io.byte_out, 0);
    check("mid_rst_busy", io.busy, 0);
    check("mid_rst_code", io.err_code, 0);
    check("mid_rst_end", io.frame_end, 0);
    check("mid_rst_start", io.frame_start, 0);
    check("mid_rst_resync", io.demod_resync, 0);
    rst = 1'b0;
    io.byte_ready = 1'b1;
    step();
    step();
    check("post_rst_valid", io.byte_valid, 0);
    check("post_rst_busy", io.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demod_frame_ctrl.md
Name: demod_frame_ctrl

Overview:
- Frame-level receive controller downstream of the QPSK correlator demodulator.
- Consumes the demodulator's 2-bit symbol stream and hunts for a sync word.
- Parses a length-prefixed frame with an 8-bit sum checksum, and delivers payload bytes through a small FIFO with valid/ready handshake.
- Sequences the demodulator: pulses a resync request after every frame end, error or timeout, so the demodulator re-acquires the next frame header.

Parameters:
- SYNC_WORD, 16'h1ACF, sync pattern; matched MSB-first at symbol granularity.
- MAX_LEN, 8'd64, largest legal payload length in bytes.
- TIMEOUT, 16'd4096, clk_fast cycles without sym_valid that abort a frame in progress.
- FIFO_DEPTH, 4, payload FIFO entries; power of two, at least 2.

Ports:
- clk_fast  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- sym_in  in  2  demodulated symbol, MSB is the earlier bit.
- sym_valid  in  1  one-cycle strobe, sym_in valid.
- demod_locked  in  1  demodulator sync done and symbol output valid.
- demod_resync  out  1  one-cycle request to restart demodulator header sync.
- byte_out  out  8  payload byte at FIFO head.
- byte_valid  out  1  FIFO non-empty.
- byte_ready  in  1  consumer accepts byte_out when byte_valid & byte_ready.
- frame_start  out  1  one-cycle pulse, sync word found.
- frame_end  out  1  one-cycle pulse, frame finished (good or bad).
- frame_err  out  1  qualifies frame_end; high means the frame is bad.
- err_code  out  2  0 CSUM, 1 LEN, 2 OVF, 3 TMO/lock loss; held until next frame_start.
- busy  out  1  state not IDLE/HUNT.

Behaviour:
- Clock and reset: one clock (clk_fast); rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters and shift register 0.
- A reset mid-frame discards everything, including FIFO contents.
- Symbol shift register: sh <= {sh[13:0], sym_in} on every sym_valid in HUNT.
- Byte assembly: 4 symbols per byte, first symbol in bits [7:6]. A 2-bit symbol counter is cleared on entering LEN.

State machine:
- IDLE: go to HUNT when demod_locked = 1.
- HUNT: on a sym_valid cycle where the updated sh == SYNC_WORD, go to LEN.
  - frame_start pulses the next cycle.
  - err_code cleared, checksum cleared.
- LEN: on byte completion:
  - len == 0 or len > MAX_LEN: abort with LEN.
  - Otherwise store rem = len, sum = len, go to PAYLOAD.
- PAYLOAD: on each completed byte:
  - Push to FIFO, sum += byte (mod 256), rem -= 1.
  - rem reaching 0 goes to CHECK.
- CHECK: on byte completion, frame_end pulses the next cycle with frame_err = (byte != sum), err_code 0 if bad. Then go to RESYNC.
- RESYNC: demod_resync = 1 for exactly one cycle, then go to IDLE.
  - The demodulator drops demod_locked in response; IDLE waits for it to return.
- Abort (any error): frame_end and frame_err pulse together, err_code latched, go to RESYNC.

Timeout and lock loss:
- In LEN/PAYLOAD/CHECK a 16-bit counter is cleared on sym_valid and increments otherwise.
- Reaching TIMEOUT aborts with code 3.
- demod_locked falling in LEN/PAYLOAD/CHECK aborts with code 3 the same cycle.
- demod_locked falling in HUNT returns to IDLE without error.

Latency and FIFO:
- A byte's 4th sym_valid at cycle t gives byte_valid = 1 at t+1 (FIFO was empty).
- First-word-fall-through, registered outputs.
- Simultaneous push and pop when full is legal: no overflow, occupancy unchanged.
- Push while full with no pop: byte dropped, abort with OVF.
- FIFO contents are not flushed on abort; the consumer uses frame_err.

Boundary cases:
- sym_valid arriving in RESYNC or IDLE is ignored.
- A sync match that straddles an aborted frame is not possible, because sh is cleared on leaving HUNT.
- LEN = MAX_LEN is legal.

Decomposition:
- Package demod_pkg holds:
  - the state enum (IDLE, HUNT, LEN, PAYLOAD, CHECK, RESYNC);
  - the err_code localparams (ERR_CSUM, ERR_LEN, ERR_OVF, ERR_TMO);
  - the symbol width constant.
- Sub-module sync_fifo (parameter WIDTH, DEPTH): FWFT, with full/empty flags and simultaneous push/pop support.

Test Plan:
- Good frame: lock, then symbols for 1ACF, len 03, payload 11 22 33, checksum 69.
  - Expect frame_start once, bytes 11, 22, 33 in order with byte_ready = 1.
  - Expect frame_end with frame_err = 0, then demod_resync pulse, then IDLE.
- Bad checksum: same frame with checksum 68 -> frame_end with frame_err = 1, err_code = 0; bytes still delivered.
- Bad length: len 00, then a separate frame with len 41 (MAX_LEN 64 = 0x40) -> each aborts with err_code = 1; no FIFO push; demod_resync pulses.
- Backpressure: byte_ready = 0, len 06 with FIFO_DEPTH 4.
  - 5th byte overflows: err_code = 2, FIFO holds the first 4 bytes.
  - Rerun with byte_ready toggled every cycle: no overflow.
- Timeout and lock loss:
  - Stop sym_valid after len: abort exactly at TIMEOUT cycles with err_code = 3.
  - Separately, drop demod_locked mid-payload: abort the same cycle, err_code = 3.
- Reset mid-PAYLOAD with 2 bytes queued: all outputs 0 the next cycle, FIFO empty, state IDLE.
